mmio_uart_tx: RTL and testbench
===============================

// Module: mmio_uart_tx
// PURPOSE
// - Memory-mapped UART transmitter; a responder on the CPU data-memory bus beside mem_data_ram.
// - The CPU writes bytes into a small TX FIFO and polls a status register.
// - The block serialises the bytes as 8N1 on the tx pin.
// - The SoC top steers CPU read data using the sel output.
// PARAMETERS
// - BASE_ADDR     32'h0001_0000  base of a 16-byte register window; bits [3:0] must be 0
// - CLKS_PER_BIT  16             clk cycles per UART bit; legal range >= 2
// - FIFO_AW       2              FIFO address width; depth = 2**FIFO_AW; legal range 1..3
// PORTS
// - clk             in   1   system clock; all state updates on posedge
// - reset           in   1   synchronous, active-high
// - addr_bus        in   32  CPU data-bus byte address
// - write_data_bus  in   32  CPU write data; only [7:0] or [3] used
// - write_signal    in   1   write strobe, sampled at posedge
// - read_data_bus   out  32  combinational read data; 0 when not selected
// - sel             out  1   combinational: addr_bus[31:4] == BASE_ADDR[31:4]
// - tx              out  1   registered serial output; idle high
// BEHAVIOUR
// - Decode: selected when sel=1; register picked by addr_bus[3:2]; addr_bus[1:0] ignored.
// - Offset 0x0 TXDATA (write): push write_data_bus[7:0]. Reads return 0.
// - Offset 0x4 STATUS (read):
//   - [0] busy: FSM != IDLE
//   - [1] full
//   - [2] empty
//   - [3] overflow: sticky
//   - [7:4] count, zero-extended
//   - [31:8] = 0
// - STATUS write: write_data_bus[3]=1 clears overflow; bit 3 = 0 has no effect.
// - Offsets 0x8 and 0xC: reads return 0; writes are ignored.
// - Write semantics: takes effect at the posedge where write_signal=1 and sel=1. No wait states.
// - FIFO push vs full:
//   - Push is dropped if full, judged on the count before the edge.
//   - A dropped push sets overflow.
//   - A pop in the same edge does not rescue the push.
//   - A simultaneous push and pop when not full leaves count unchanged.
// - FIFO: circular; pointers wrap modulo depth; count width FIFO_AW+1.
// - FSM states: IDLE, START, DATA, STOP.
//   - IDLE: tx=1. If FIFO is non-empty at the edge, pop into an 8-bit shift register, clear the
//     baud counter and bit index, go to START.
//   - START: tx=0 for CLKS_PER_BIT cycles, then DATA.
//   - DATA: tx = shift[0], LSB first. Each bit lasts CLKS_PER_BIT cycles, then shift right. After
//     bit index 7 completes, go to STOP.
//   - STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE.
// - Frame length: 10*CLKS_PER_BIT cycles.
// - Back-to-back frames are separated by exactly 1 IDLE cycle (tx=1).
// - Latency: a write at edge E to an empty FIFO with FSM idle pops at E+1, and tx=0 from E+1.
// - Baud counter counts 0..CLKS_PER_BIT-1 and wraps on each bit boundary.
// - Reset values: tx=1, FSM=IDLE, FIFO empty, count=0, overflow=0, shift/baud/bit index=0.
// - Reset mid-frame: the frame is aborted, tx=1 after the reset edge, and the FIFO contents are
//   discarded.
// - Reset has priority over a simultaneous write.
// TESTING
// - All tests use CLKS_PER_BIT=4 and FIFO_AW=2.
// - T1 reset: assert reset for 2 edges -> tx=1; read BASE+4 = 32'h0000_0004; sel=0 for addr 0.
// - T2 single byte: write 0x55 to BASE+0 at edge E -> tx low for E+1..E+4; then 1,0,1,0,1,0,1,0
//   at 4 cycles each; stop high; STATUS=0x04 after E+41.
// - T3 overflow: 6 writes on consecutive edges (0x01..0x06) -> 0x01..0x05 transmitted in order;
//   0x06 dropped; STATUS[3]=1; STATUS[1]=1 after the 5th write.
// - T4 overflow clear: write 0x0 to BASE+4 -> overflow stays 1; write 0x8 -> overflow=0.
// - T5 decode: write 0xAA to BASE+0x10 and BASE+0x8 -> no push, tx stays high; reads at BASE+0x10
//   return 0 with sel=0.
// - T6 reset mid-frame: reset during DATA with 2 bytes queued -> tx=1 the next cycle;
//   STATUS=0x04; no further frames.

Source files
------------

// File: rtl/mmio_uart_tx_if.sv
// CPU data-memory bus seen by the memory-mapped UART transmitter.
// The CPU side drives address, write data and write strobe. The UART side
// returns combinational read data and its window-select flag.
interface mmio_uart_tx_if;
    logic [31:0] addr_bus;
    logic [31:0] write_data_bus;
    logic        write_signal;
    logic [31:0] read_data_bus;
    logic        sel;

    modport master (
        output addr_bus,
        output write_data_bus,
        output write_signal,
        input  read_data_bus,
        input  sel
    );

    modport slave (
        input  addr_bus,
        input  write_data_bus,
        input  write_signal,
        output read_data_bus,
        output sel
    );
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a small TX FIFO.
// Register window (16 bytes at BASE_ADDR, decoded on addr_bus[3:2]):
//   0x0 TXDATA  write pushes a byte, read returns 0
//   0x4 STATUS  {count, overflow, empty, full, busy}; writing bit 3 clears overflow
//   0x8 / 0xC   reserved, read as 0, writes ignored
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR    = 32'h0001_0000,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_AW      = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    mmio_uart_tx_if.slave        bus,
    output logic                 tx
);

    localparam int DEPTH  = 2 ** FIFO_AW;
    localparam int CNT_W  = FIFO_AW + 1;
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [CNT_W-1:0]   CNT_DEPTH = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]   CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE   = FIFO_AW'(1);
    localparam logic [BAUD_W-1:0]  BAUD_ZERO = BAUD_W'(0);
    localparam logic [BAUD_W-1:0]  BAUD_ONE  = BAUD_W'(1);
    localparam logic [BAUD_W-1:0]  BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_START = 2'b01,
        ST_DATA  = 2'b10,
        ST_STOP  = 2'b11
    } state_t;

    // Registered state
    state_t             r_state;
    logic [7:0]         r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               r_overflow;
    logic [7:0]         r_shift;
    logic [BAUD_W-1:0]  r_baud;
    logic [2:0]         r_bit_idx;
    logic               r_tx;

    // Combinational signals
    logic               w_sel;
    logic               w_wr_txdata;
    logic               w_wr_status;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_drop;
    logic               w_pop;
    state_t             w_next_state;
    logic [7:0]         w_next_shift;
    logic [BAUD_W-1:0]  w_next_baud;
    logic [2:0]         w_next_bit;
    logic               w_next_tx;
    logic [CNT_W-1:0]   w_next_count;
    logic [3:0]         w_count4;
    logic [31:0]        w_status;
    logic [31:0]        w_rdata;
    logic               w_unused_bits;

    // Upper write-data bits and byte-lane address bits carry no meaning here.
    assign w_unused_bits = ^{bus.write_data_bus[31:8], bus.addr_bus[1:0]};

    assign w_sel   = (bus.addr_bus[31:4] == BASE_ADDR[31:4]);
    assign w_full  = (r_count == CNT_DEPTH);
    assign w_empty = (r_count == CNT_ZERO);

    // Address decode of CPU writes into TXDATA and STATUS strobes.
    always_comb begin
        w_wr_txdata = 1'b0;
        w_wr_status = 1'b0;
        if (w_sel && bus.write_signal) begin
            w_wr_txdata = (bus.addr_bus[3:2] == 2'b00);
            w_wr_status = (bus.addr_bus[3:2] == 2'b01);
        end else begin
            w_wr_txdata = 1'b0;
            w_wr_status = 1'b0;
        end
    end

    // A push into a full FIFO is dropped even if a pop happens on the same edge.
    assign w_push = w_wr_txdata & ~w_full;
    assign w_drop = w_wr_txdata & w_full;

    // FIFO occupancy update from the push/pop pair.
    always_comb begin
        w_next_count = r_count;
        case ({w_push, w_pop})
            2'b10:   w_next_count = r_count + CNT_ONE;
            2'b01:   w_next_count = r_count - CNT_ONE;
            default: w_next_count = r_count;
        endcase
    end

    // Transmit FSM next state, datapath next values and next serial bit.
    always_comb begin
        w_next_state = r_state;
        w_next_shift = r_shift;
        w_next_baud  = r_baud;
        w_next_bit   = r_bit_idx;
        w_pop        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_next_shift = r_mem[r_rd_ptr];
                    w_next_baud  = BAUD_ZERO;
                    w_next_bit   = 3'd0;
                    w_next_state = ST_START;
                end else begin
                    w_pop        = 1'b0;
                end
            end
            ST_START: begin
                if (r_baud == BAUD_LAST) begin
                    w_next_baud  = BAUD_ZERO;
                    w_next_state = ST_DATA;
                end else begin
                    w_next_baud  = r_baud + BAUD_ONE;
                end
            end
            ST_DATA: begin
                if (r_baud == BAUD_LAST) begin
                    w_next_baud  = BAUD_ZERO;
                    w_next_shift = {1'b0, r_shift[7:1]};
                    if (r_bit_idx == 3'd7) begin
                        w_next_bit   = 3'd0;
                        w_next_state = ST_STOP;
                    end else begin
                        w_next_bit   = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_next_baud  = r_baud + BAUD_ONE;
                end
            end
            ST_STOP: begin
                if (r_baud == BAUD_LAST) begin
                    w_next_baud  = BAUD_ZERO;
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_baud  = r_baud + BAUD_ONE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase

        // tx is registered, so it follows the state being entered, not the current one.
        case (w_next_state)
            ST_IDLE:  w_next_tx = 1'b1;
            ST_START: w_next_tx = 1'b0;
            ST_DATA:  w_next_tx = w_next_shift[0];
            ST_STOP:  w_next_tx = 1'b1;
            default:  w_next_tx = 1'b1;
        endcase
    end

    // FSM, FIFO bookkeeping and serial output registers; reset wins over any write.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= CNT_ZERO;
            r_overflow <= 1'b0;
            r_shift    <= 8'h00;
            r_baud     <= BAUD_ZERO;
            r_bit_idx  <= 3'd0;
            r_tx       <= 1'b1;
        end else begin
            r_state   <= w_next_state;
            r_shift   <= w_next_shift;
            r_baud    <= w_next_baud;
            r_bit_idx <= w_next_bit;
            r_tx      <= w_next_tx;
            r_count   <= w_next_count;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (w_wr_status && bus.write_data_bus[3]) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // FIFO storage; stale entries are harmless because the pointers are reset.
    always_ff @(posedge clk) begin
        if (w_push && !reset) begin
            r_mem[r_wr_ptr] <= bus.write_data_bus[7:0];
        end
    end

    // Zero-extend the occupancy into the 4-bit STATUS count field.
    always_comb begin
        w_count4 = 4'h0;
        w_count4[CNT_W-1:0] = r_count;
    end

    assign w_status = {24'h00_0000, w_count4, r_overflow, w_empty, w_full,
                       (r_state != ST_IDLE)};

    // Read mux: only STATUS returns data; everything else, and unselected, reads 0.
    always_comb begin
        w_rdata = 32'h0000_0000;
        if (w_sel && (bus.addr_bus[3:2] == 2'b01)) begin
            w_rdata = w_status;
        end else begin
            w_rdata = 32'h0000_0000;
        end
    end

    assign bus.read_data_bus = w_rdata;
    assign bus.sel           = w_sel;
    assign tx                = r_tx;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx at CLKS_PER_BIT=4, FIFO_AW=2.
// A frame decoder compares every received byte against a scoreboard queue
// filled when bytes are written.
module tb_mmio_uart_tx;

    localparam logic [31:0] BASE = 32'h0001_0000;

    logic clk;
    logic reset;
    logic tx;
    int   total;
    int   bad;
    logic [7:0] sb_q [$];

    mmio_uart_tx_if bus_if ();

    mmio_uart_tx #(
        .BASE_ADDR   (BASE),
        .CLKS_PER_BIT(4),
        .FIFO_AW     (2)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_if),
        .tx   (tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Frame decoder: start detected at the first low negedge sample, bits sampled mid-bit.
    initial begin : monitor
        bit         busy;
        int         cyc;
        logic [7:0] rx;
        logic [7:0] exp_b;
        busy = 1'b0;
        cyc  = 0;
        rx   = 8'h00;
        forever begin
            @(negedge clk);
            if (reset === 1'b1) begin
                busy = 1'b0;
            end else if (!busy) begin
                if (tx === 1'b0) begin
                    busy = 1'b1;
                    cyc  = 0;
                    rx   = 8'h00;
                end
            end else begin
                cyc = cyc + 1;
                if (cyc == 2) begin
                    total++;
                    if (tx !== 1'b0) begin
                        bad++;
                        $display("FAIL start_bit: got %b want 0", tx);
                    end
                end else if (cyc >= 6 && cyc <= 34 && ((cyc - 6) % 4) == 0) begin
                    rx[(cyc - 6) / 4] = tx;
                end else if (cyc == 38) begin
                    total++;
                    if (tx !== 1'b1) begin
                        bad++;
                        $display("FAIL stop_bit: got %b want 1", tx);
                    end
                    total++;
                    if (sb_q.size() == 0) begin
                        bad++;
                        $display("FAIL frame_unexpected: got %h want no frame", rx);
                    end else begin
                        exp_b = sb_q.pop_front();
                        if (rx !== exp_b) begin
                            bad++;
                            $display("FAIL frame_data: got %h want %h", rx, exp_b);
                        end
                    end
                    busy = 1'b0;
                end
            end
        end
    end

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bus_if.addr_bus       = a;
        bus_if.write_data_bus = d;
        bus_if.write_signal   = 1'b1;
        @(posedge clk);
        #1;
        bus_if.write_signal   = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic s);
        bus_if.addr_bus     = a;
        bus_if.write_signal = 1'b0;
        #1;
        d = bus_if.read_data_bus;
        s = bus_if.sel;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic        s;
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        total++;
        if (tx !== 1'b1) begin
            bad++;
            $display("FAIL reset_tx: got %b want 1", tx);
        end
        bus_read(BASE + 32'h4, d, s);
        total++;
        if (d !== 32'h0000_0004) begin
            bad++;
            $display("FAIL reset_status: got %h want 00000004", d);
        end
        bus_read(32'h0000_0000, d, s);
        total++;
        if (s !== 1'b0 || d !== 32'h0) begin
            bad++;
            $display("FAIL reset_sel0: got sel=%b data=%h want sel=0 data=0", s, d);
        end
    endtask

    task automatic test_single_byte();
        logic [31:0] d;
        logic        s;
        logic [7:0]  pat;
        logic        exp_tx;
        pat = 8'h55;
        sb_q.push_back(pat);
        bus_write(BASE, {24'h0, pat});
        for (int k = 0; k <= 41; k++) begin
            @(negedge clk);
            if (k == 0)       exp_tx = 1'b1;
            else if (k <= 4)  exp_tx = 1'b0;
            else if (k <= 36) exp_tx = pat[(k - 5) / 4];
            else              exp_tx = 1'b1;
            total++;
            if (tx !== exp_tx) begin
                bad++;
                $display("FAIL single_tx k=%0d: got %b want %b", k, tx, exp_tx);
            end
            if (k == 40) begin
                bus_read(BASE + 32'h4, d, s);
                total++;
                if (d !== 32'h0000_0005) begin
                    bad++;
                    $display("FAIL single_status_stop: got %h want 00000005", d);
                end
            end
            if (k == 41) begin
                bus_read(BASE + 32'h4, d, s);
                total++;
                if (d !== 32'h0000_0004) begin
                    bad++;
                    $display("FAIL single_status_idle: got %h want 00000004", d);
                end
            end
        end
    endtask

    task automatic test_overflow();
        logic [31:0] d;
        logic        s;
        bit          done;
        for (int i = 1; i <= 6; i++) begin
            if (i <= 5) sb_q.push_back(8'(i));
            bus_write(BASE, 32'(i));
            if (i == 5) begin
                bus_read(BASE + 32'h4, d, s);
                total++;
                if (d[1] !== 1'b1 || d !== 32'h0000_0043) begin
                    bad++;
                    $display("FAIL ovf_full: got %h want 00000043", d);
                end
            end
        end
        bus_read(BASE + 32'h4, d, s);
        total++;
        if (d !== 32'h0000_004B) begin
            bad++;
            $display("FAIL ovf_set: got %h want 0000004b", d);
        end
        done = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            bus_read(BASE + 32'h4, d, s);
            if (sb_q.size() == 0 && d == 32'h0000_000C) begin
                done = 1'b1;
                break;
            end
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL ovf_drain: got status=%h left=%0d want 0000000c left=0", d, sb_q.size());
        end
    endtask

    task automatic test_overflow_clear();
        logic [31:0] d;
        logic        s;
        bus_write(BASE + 32'h4, 32'h0);
        bus_read(BASE + 32'h4, d, s);
        total++;
        if (d !== 32'h0000_000C) begin
            bad++;
            $display("FAIL ovf_keep: got %h want 0000000c", d);
        end
        bus_write(BASE + 32'h4, 32'h8);
        bus_read(BASE + 32'h4, d, s);
        total++;
        if (d !== 32'h0000_0004) begin
            bad++;
            $display("FAIL ovf_clear: got %h want 00000004", d);
        end
    endtask

    task automatic test_decode();
        logic [31:0] d;
        logic        s;
        bit          stayed_high;
        bus_write(BASE + 32'h10, 32'hAA);
        bus_write(BASE + 32'h8, 32'hAA);
        stayed_high = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) stayed_high = 1'b0;
        end
        total++;
        if (!stayed_high) begin
            bad++;
            $display("FAIL decode_tx_idle: got a low tx want constant 1");
        end
        bus_read(BASE + 32'h4, d, s);
        total++;
        if (d !== 32'h0000_0004) begin
            bad++;
            $display("FAIL decode_status: got %h want 00000004", d);
        end
        bus_read(BASE + 32'h10, d, s);
        total++;
        if (s !== 1'b0 || d !== 32'h0) begin
            bad++;
            $display("FAIL decode_outside: got sel=%b data=%h want sel=0 data=0", s, d);
        end
        bus_read(BASE + 32'h8, d, s);
        total++;
        if (s !== 1'b1 || d !== 32'h0) begin
            bad++;
            $display("FAIL decode_rsvd: got sel=%b data=%h want sel=1 data=0", s, d);
        end
        bus_read(BASE, d, s);
        total++;
        if (s !== 1'b1 || d !== 32'h0) begin
            bad++;
            $display("FAIL decode_txdata_rd: got sel=%b data=%h want sel=1 data=0", s, d);
        end
    endtask

    task automatic test_reset_midframe();
        logic [31:0] d;
        logic        s;
        bit          stayed_high;
        sb_q.push_back(8'h11);
        bus_write(BASE, 32'h11);
        sb_q.push_back(8'h22);
        bus_write(BASE, 32'h22);
        sb_q.push_back(8'h33);
        bus_write(BASE, 32'h33);
        repeat (12) @(negedge clk);
        bus_read(BASE + 32'h4, d, s);
        total++;
        if (d !== 32'h0000_0021) begin
            bad++;
            $display("FAIL midframe_pre: got %h want 00000021", d);
        end
        @(negedge clk);
        sb_q.delete();
        reset                 = 1'b1;
        bus_if.addr_bus       = BASE;
        bus_if.write_data_bus = 32'h44;
        bus_if.write_signal   = 1'b1;
        @(posedge clk);
        #1;
        bus_if.write_signal   = 1'b0;
        total++;
        if (tx !== 1'b1) begin
            bad++;
            $display("FAIL midframe_tx: got %b want 1", tx);
        end
        bus_read(BASE + 32'h4, d, s);
        total++;
        if (d !== 32'h0000_0004) begin
            bad++;
            $display("FAIL midframe_status: got %h want 00000004", d);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        stayed_high = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) stayed_high = 1'b0;
        end
        total++;
        if (!stayed_high) begin
            bad++;
            $display("FAIL midframe_no_frames: got a low tx want constant 1");
        end
        bus_read(BASE + 32'h4, d, s);
        total++;
        if (d !== 32'h0000_0004) begin
            bad++;
            $display("FAIL midframe_final: got %h want 00000004", d);
        end
    endtask

    initial begin
        total                 = 0;
        bad                   = 0;
        reset                 = 1'b1;
        bus_if.addr_bus       = 32'h0;
        bus_if.write_data_bus = 32'h0;
        bus_if.write_signal   = 1'b0;
        test_reset();
        test_single_byte();
        test_overflow();
        test_overflow_clear();
        test_decode();
        test_reset_midframe();
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover: got %0d pending want 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
